// File: rtl/mem_responder_pkg.sv
// Shared widths, FSM state type and counter type for the memory responder slice.
package mem_responder_pkg;

    localparam int unsigned RISCV_ADDR_WIDTH   = 32;
    localparam int unsigned RISCV_WORD_WIDTH   = 32;
    localparam int unsigned MEM_WAIT_CNT_WIDTH = 4;
    localparam int unsigned MEM_BE_WIDTH       = RISCV_WORD_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } mem_state_e;

    typedef logic [MEM_WAIT_CNT_WIDTH-1:0] wait_cnt_t;

endpackage

// File: rtl/sram_1rw.sv
// Synchronous single-read/single-write RAM with byte-lane write enables;
// read data is registered and only updates on rd_en.
module sram_1rw #(
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned AW        = $clog2(DEPTH),
  parameter              INIT_FILE = ""
) (
  input  logic               clk,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_addr,
  output logic [WIDTH-1:0]   rd_data,
  input  logic [WIDTH/8-1:0] wr_be,
  input  logic [AW-1:0]      wr_addr,
  input  logic [WIDTH-1:0]   wr_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    for (int unsigned b = 0; b < WIDTH / 8; b++) begin
      if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Valid/ready memory target: programmable wait states, byte-lane writes and
// out-of-window error reporting in front of a word-wide sram_1rw.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned                 DEPTH_WORDS = 4096,
    parameter logic [RISCV_ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0,
    parameter int unsigned                 WAIT_CYCLES = 0,
    parameter                              INIT_FILE   = ""
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic [RISCV_ADDR_WIDTH-1:0] addr_i,
    input  logic [RISCV_WORD_WIDTH-1:0] wdata_i,
    input  logic [MEM_BE_WIDTH-1:0]     we_i,
    output logic [RISCV_WORD_WIDTH-1:0] rdata_o,
    output logic                        err_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    mem_state_e                  state, state_n;
    wait_cnt_t                   cnt;
    logic [IDX_W-1:0]            idx_q, idx_in, rd_idx;
    logic [RISCV_WORD_WIDTH-1:0] wdata_q, ram_rdata;
    logic [MEM_BE_WIDTH-1:0]     we_q, wr_be;
    logic [RISCV_ADDR_WIDTH-1:0] off;
    logic                        addr_ok, oor_q, zero_q;
    logic                        rd_en, rd_oor;

    always_comb begin
        off     = addr_i - BASE_ADDR;
        idx_in  = off[IDX_W+1:2];
        addr_ok = (addr_i >= BASE_ADDR) && ((off >> 2) < RISCV_ADDR_WIDTH'(DEPTH_WORDS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (valid_i) state_n = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
            ST_WAIT: begin
                if (!valid_i)                      state_n = ST_IDLE;
                else if (cnt == wait_cnt_t'(1))    state_n = ST_RESP;
            end
            ST_RESP: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            we_q    <= '0;
            oor_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            if (state == ST_IDLE && valid_i) begin
                cnt     <= wait_cnt_t'(WAIT_CYCLES);
                idx_q   <= idx_in;
                wdata_q <= wdata_i;
                we_q    <= we_i;
                oor_q   <= !addr_ok;
            end else if (state == ST_WAIT) begin
                cnt <= cnt - wait_cnt_t'(1);
            end
            if (rd_en) zero_q <= rd_oor;
        end
    end

    // The RAM read is issued on the edge that enters RESP; with no wait states that
    // is the accept edge itself, so the live request address is used there.
    always_comb begin
        rd_en   = 1'b0;
        rd_idx  = idx_q;
        rd_oor  = oor_q;
        if (state == ST_IDLE) begin
            rd_en  = valid_i && (WAIT_CYCLES == 0);
            rd_idx = idx_in;
            rd_oor = !addr_ok;
        end else if (state == ST_WAIT) begin
            rd_en  = valid_i && (cnt == wait_cnt_t'(1));
        end
        wr_be   = (state == ST_RESP && !oor_q) ? we_q : '0;
        ready_o = (state == ST_RESP);
        err_o   = (state == ST_RESP) && oor_q;
        rdata_o = zero_q ? '0 : ram_rdata;
    end

    sram_1rw #(
        .DEPTH     (DEPTH_WORDS),
        .WIDTH     (RISCV_WORD_WIDTH),
        .AW        (IDX_W),
        .INIT_FILE (INIT_FILE)
    ) u_sram (
        .clk     (clk),
        .rd_en   (rd_en),
        .rd_addr (rd_idx),
        .rd_data (ram_rdata),
        .wr_be   (wr_be),
        .wr_addr (idx_q),
        .wr_data (wdata_q)
    );

endmodule
